// File: rtl/intra4x4_pred_engine.sv
// intra4x4_pred_engine
//   Walks a frame of 4x4 blocks in raster order. For each block it fetches four pixel
//   rows, builds DC / horizontal / vertical residuals against neighbour caches, picks
//   one (forced or minimum SAD) and offers it to the DCT stage.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start               begin a frame (only looked at in IDLE)
//   mode_cfg            00 DC, 01 H, 10 V, 11 auto; latched when a block's fetch begins
//   fetch_req/addr      row fetch request and pixel-row address
//   fetch_valid/data    row returned; completes one fetch beat
//   res_valid/ready     residual handshake towards the DCT stage
//   res_data/mode/sad   signed residuals (k = 4*row+col), chosen mode, its SAD
//   busy, frame_done    activity flag, one-cycle end-of-frame pulse
//   dbg_state           current FSM state
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both high.
// fetch_req and res_valid, once raised, stay high with address/data unchanged until
// that transfer; fetch_valid is only honoured while fetch_req is high.
module intra4x4_pred_engine #(
    parameter int PIX_W    = 8,
    parameter int BLK_COLS = 64,
    parameter int BLK_ROWS = 64,
    parameter int ADDR_W   = 14
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [1:0]               mode_cfg,
    output logic                     fetch_req,
    output logic [ADDR_W-1:0]        fetch_addr,
    input  logic                     fetch_valid,
    input  logic [4*PIX_W-1:0]       fetch_data,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [16*(PIX_W+1)-1:0]  res_data,
    output logic [1:0]               res_mode,
    output logic [PIX_W+3:0]         res_sad,
    output logic                     busy,
    output logic                     frame_done,
    output logic [2:0]               dbg_state
);

    localparam int RES_W = PIX_W + 1;
    localparam int SAD_W = PIX_W + 4;
    localparam int COL_W = (BLK_COLS > 1) ? $clog2(BLK_COLS) : 1;
    localparam int ROW_W = (BLK_ROWS > 1) ? $clog2(BLK_ROWS) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_CALC  = 3'd2,
        S_OUT   = 3'd3
    } state_t;

    state_t             state, state_d;
    logic [ROW_W-1:0]   blk_row;
    logic [COL_W-1:0]   blk_col;
    logic [1:0]         beat;
    logic [1:0]         mode_q;
    logic [PIX_W-1:0]   cur_pix    [16];
    logic [PIX_W-1:0]   top_cache  [BLK_COLS][4];
    logic [PIX_W-1:0]   left_cache [4];
    logic [PIX_W-1:0]   top_row    [4];

    logic               last_blk, hs, beat_done;
    logic               top_av, left_av;
    logic [SAD_W-1:0]   sum_t, sum_l, dc_tmp;
    logic [PIX_W-1:0]   dc_pred;
    logic [RES_W-1:0]   res_dc [16];
    logic [RES_W-1:0]   res_h  [16];
    logic [RES_W-1:0]   res_v  [16];
    logic [SAD_W-1:0]   sad_dc, sad_h, sad_v, sad_sel;
    logic [1:0]         sel;
    logic [16*RES_W-1:0] res_sel;

    function automatic logic [PIX_W-1:0] abs_res(input logic [RES_W-1:0] v);
        logic [RES_W-1:0] m;
        m = v[RES_W-1] ? ('0 - v) : v;
        return m[PIX_W-1:0];
    endfunction

    assign last_blk  = (blk_row == ROW_W'(BLK_ROWS - 1)) && (blk_col == COL_W'(BLK_COLS - 1));
    assign hs        = (state == S_OUT) && res_ready;
    assign beat_done = (state == S_FETCH) && fetch_valid;

    assign fetch_req  = (state == S_FETCH);
    // {blk_row, beat} is blk_row*4 + r, the pixel-row index within the frame
    assign fetch_addr = (state == S_FETCH)
                      ? ADDR_W'({blk_row, beat}) * ADDR_W'(BLK_COLS) + ADDR_W'(blk_col)
                      : '0;
    assign res_valid  = (state == S_OUT);
    assign busy       = (state != S_IDLE);
    assign dbg_state  = state;

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  if (start) state_d = S_FETCH;
            S_FETCH: if (fetch_valid && beat == 2'd3) state_d = S_CALC;
            S_CALC:  state_d = S_OUT;
            S_OUT:   if (res_ready) state_d = last_blk ? S_IDLE : S_FETCH;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            blk_row    <= '0;
            blk_col    <= '0;
            beat       <= '0;
            mode_q     <= '0;
            res_data   <= '0;
            res_mode   <= '0;
            res_sad    <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_d;
            frame_done <= hs && last_blk;
            if (state == S_IDLE && start) begin
                blk_row <= '0;
                blk_col <= '0;
                beat    <= '0;
                mode_q  <= mode_cfg;
            end
            if (beat_done) beat <= beat + 2'd1;
            if (state == S_CALC) begin
                res_data <= res_sel;
                res_mode <= sel;
                res_sad  <= sad_sel;
            end
            if (hs && !last_blk) begin
                mode_q <= mode_cfg;
                if (blk_col == COL_W'(BLK_COLS - 1)) begin
                    blk_col <= '0;
                    blk_row <= blk_row + ROW_W'(1);
                end else begin
                    blk_col <= blk_col + COL_W'(1);
                end
            end
        end
    end

    // Pixel storage and neighbour caches carry no reset: availability comes from the
    // block position, so stale contents are never used.
    always_ff @(posedge clk) begin
        if (beat_done) begin
            for (int c = 0; c < 4; c++)
                cur_pix[{beat, 2'(c)}] <= fetch_data[c*PIX_W +: PIX_W];
        end
        if (hs) begin
            for (int i = 0; i < 4; i++) begin
                top_cache[blk_col][i] <= cur_pix[12 + i];
                left_cache[i]         <= cur_pix[4*i + 3];
            end
        end
    end

    always_comb begin
        top_av = (blk_row != '0);
        left_av = (blk_col != '0);
        sum_t = '0;
        sum_l = '0;
        for (int i = 0; i < 4; i++) begin
            top_row[i] = top_cache[blk_col][i];
            sum_t = sum_t + SAD_W'(top_row[i]);
            sum_l = sum_l + SAD_W'(left_cache[i]);
        end
        if (top_av && left_av)  dc_tmp = (sum_t + sum_l + SAD_W'(4)) >> 3;
        else if (top_av)        dc_tmp = (sum_t + SAD_W'(2)) >> 2;
        else if (left_av)       dc_tmp = (sum_l + SAD_W'(2)) >> 2;
        else                    dc_tmp = SAD_W'(1) << (PIX_W - 1);
        dc_pred = dc_tmp[PIX_W-1:0];

        sad_dc = '0;
        sad_h  = '0;
        sad_v  = '0;
        for (int k = 0; k < 16; k++) begin
            res_dc[k] = {1'b0, cur_pix[k]} - {1'b0, dc_pred};
            res_h[k]  = {1'b0, cur_pix[k]} - {1'b0, left_cache[k/4]};
            res_v[k]  = {1'b0, cur_pix[k]} - {1'b0, top_row[k%4]};
            sad_dc = sad_dc + SAD_W'(abs_res(res_dc[k]));
            sad_h  = sad_h  + SAD_W'(abs_res(res_h[k]));
            sad_v  = sad_v  + SAD_W'(abs_res(res_v[k]));
        end

        // Strict '<' keeps the earlier candidate on ties: DC beats V beats H.
        sel = 2'b00;
        sad_sel = sad_dc;
        case (mode_q)
            2'b01: if (left_av) sel = 2'b01;
            2'b10: if (top_av)  sel = 2'b10;
            2'b11: begin
                if (top_av && sad_v < sad_sel) begin
                    sel = 2'b10;
                    sad_sel = sad_v;
                end
                if (left_av && sad_h < sad_sel) begin
                    sel = 2'b01;
                    sad_sel = sad_h;
                end
            end
            default: sel = 2'b00;
        endcase

        case (sel)
            2'b01:   sad_sel = sad_h;
            2'b10:   sad_sel = sad_v;
            default: sad_sel = sad_dc;
        endcase

        res_sel = '0;
        for (int k = 0; k < 16; k++) begin
            case (sel)
                2'b01:   res_sel[k*RES_W +: RES_W] = res_h[k];
                2'b10:   res_sel[k*RES_W +: RES_W] = res_v[k];
                default: res_sel[k*RES_W +: RES_W] = res_dc[k];
            endcase
        end
    end

endmodule

// File: tb/tb_intra4x4_pred_engine.sv
module tb_intra4x4_pred_engine;

    localparam int PIX_W    = 8;
    localparam int BLK_COLS = 2;
    localparam int BLK_ROWS = 2;
    localparam int ADDR_W   = 4;
    localparam int RES_W    = 16 * (PIX_W + 1);
    localparam int CW       = 176;

    logic                    clk;
    logic                    rst_n;
    logic                    start;
    logic [1:0]              mode_cfg;
    logic                    fetch_req;
    logic [ADDR_W-1:0]       fetch_addr;
    logic                    fetch_valid;
    logic [4*PIX_W-1:0]      fetch_data;
    logic                    res_valid;
    logic                    res_ready;
    logic [RES_W-1:0]        res_data;
    logic [1:0]              res_mode;
    logic [PIX_W+3:0]        res_sad;
    logic                    busy;
    logic                    frame_done;
    logic [2:0]              dbg_state;

    int errors = 0;
    int checks = 0;
    int fd_count = 0;
    logic always_valid = 1'b0;
    logic [4*PIX_W-1:0] img [16];
    logic [ADDR_W-1:0]  exp_addr_q [$];
    logic [157:0]       exp_q [$];
    logic [RES_W-1:0]   last_exp_data;

    intra4x4_pred_engine #(
        .PIX_W(PIX_W), .BLK_COLS(BLK_COLS), .BLK_ROWS(BLK_ROWS), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode_cfg(mode_cfg),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_valid(fetch_valid), .fetch_data(fetch_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_mode(res_mode), .res_sad(res_sad), .busy(busy),
        .frame_done(frame_done), .dbg_state(dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- stimulus helpers ----------------
    function automatic logic [RES_W-1:0] rows_res(input int r0, input int r1, input int r2, input int r3);
        logic [RES_W-1:0] d;
        int v;
        d = '0;
        for (int k = 0; k < 16; k++) begin
            case (k / 4)
                0:       v = r0;
                1:       v = r1;
                2:       v = r2;
                default: v = r3;
            endcase
            d[k*9 +: 9] = 9'(v);
        end
        return d;
    endfunction

    task automatic push_exp(input logic [1:0] m, input int sad, input logic [RES_W-1:0] d);
        exp_q.push_back({m, 12'(sad), d});
    endtask

    task automatic push_addrs();
        for (int br = 0; br < 2; br++)
            for (int bc = 0; bc < 2; bc++)
                for (int r = 0; r < 4; r++)
                    exp_addr_q.push_back(ADDR_W'((br*4 + r)*2 + bc));
    endtask

    // Image 1: flat mid-grey.
    task automatic load_img1();
        for (int a = 0; a < 16; a++) img[a] = {4{8'h80}};
    endtask

    // Image 2: top blocks rows 10/20/30/40, bottom-left 50, bottom-right 40.
    task automatic load_img2();
        int v;
        for (int y = 0; y < 8; y++)
            for (int c = 0; c < 2; c++) begin
                if (y < 4)       v = (y + 1) * 10;
                else if (c == 0) v = 50;
                else             v = 40;
                img[y*2 + c] = {4{8'(v)}};
            end
    endtask

    task automatic start_frame(input logic [1:0] m0);
        @(negedge clk);
        mode_cfg = m0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_block(input string name);
        int n;
        logic [157:0] item;
        n = 0;
        @(negedge clk);
        while (!res_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({name, "_res_valid"}, CW'(res_valid), CW'(1));
        if (exp_q.size() == 0) begin
            check({name, "_exp_underrun"}, CW'(exp_q.size()), CW'(1));
        end else begin
            item = exp_q.pop_front();
            last_exp_data = item[143:0];
            check({name, "_mode"}, CW'(res_mode), CW'(item[157:156]));
            check({name, "_sad"},  CW'(res_sad),  CW'(item[155:144]));
            check({name, "_data"}, CW'(res_data), CW'(item[143:0]));
        end
    endtask

    task automatic do_handshake(input logic [1:0] next_mode);
        mode_cfg = next_mode;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
    endtask

    // ---------------- fetch responder with address scoreboard ----------------
    initial begin
        fetch_valid = 1'b0;
        fetch_data  = '0;
        forever begin
            @(negedge clk);
            if (always_valid) fetch_valid = 1'b1;
            else              fetch_valid = fetch_req && ($urandom_range(0, 2) != 0);
            fetch_data = img[fetch_addr];
            if (fetch_req && fetch_valid && rst_n) begin
                if (exp_addr_q.size() == 0)
                    check("fetch_addr_underrun", CW'(exp_addr_q.size()), CW'(1));
                else
                    check("fetch_addr", CW'(fetch_addr), CW'(exp_addr_q.pop_front()));
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (frame_done) fd_count++;
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        mode_cfg = 2'b00;
        res_ready = 1'b0;
        load_img1();
        repeat (3) @(negedge clk);
        check("reset_outs", CW'({fetch_req, fetch_addr, res_valid, res_data, res_mode,
                                 res_sad, busy, frame_done, dbg_state}), CW'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_state", CW'({busy, dbg_state}), CW'(0));

        // Frame 1: flat image, fetch_valid always high, forced V fallback on row 0.
        always_valid = 1'b1;
        push_addrs();
        push_exp(2'b00, 0, '0);
        push_exp(2'b00, 0, '0);
        push_exp(2'b10, 0, '0);
        push_exp(2'b00, 0, '0);
        start_frame(2'b11);
        check_block("f1b0"); do_handshake(2'b10);
        check_block("f1b1"); do_handshake(2'b10);
        check_block("f1b2"); do_handshake(2'b11);
        check_block("f1b3"); do_handshake(2'b11);
        repeat (3) @(negedge clk);
        check("f1_frame_done", CW'(fd_count), CW'(1));
        check("f1_idle", CW'({busy, dbg_state}), CW'(0));
        check("f1_addr_left", CW'(exp_addr_q.size()), CW'(0));

        // Frame 2: ramp image, random fetch gaps, stall on first block.
        always_valid = 1'b0;
        load_img2();
        push_addrs();
        push_exp(2'b00, 1648, rows_res(-118, -108, -98, -88));
        push_exp(2'b01, 0, '0);
        push_exp(2'b10, 160, rows_res(10, 10, 10, 10));
        push_exp(2'b10, 0, '0);
        start_frame(2'b11);
        check_block("f2b0");
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", CW'(res_valid), CW'(1));
            check("stall_data", CW'(res_data), CW'(last_exp_data));
            check("stall_no_fetch", CW'({fetch_req, dbg_state}), CW'(3));
            @(negedge clk);
        end
        do_handshake(2'b11);
        check_block("f2b1"); do_handshake(2'b10);
        check_block("f2b2"); do_handshake(2'b11);
        check_block("f2b3"); do_handshake(2'b00);
        repeat (3) @(negedge clk);
        check("f2_frame_done", CW'(fd_count), CW'(2));
        check("f2_addr_left", CW'(exp_addr_q.size()), CW'(0));

        // Frame 3: aborted by reset while fetching the last block.
        push_addrs();
        push_exp(2'b00, 1648, rows_res(-118, -108, -98, -88));
        push_exp(2'b01, 0, '0);
        push_exp(2'b00, 160, rows_res(10, 10, 10, 10));
        start_frame(2'b11);
        check_block("f3b0"); do_handshake(2'b11);
        check_block("f3b1"); do_handshake(2'b11);
        check_block("f3b2"); do_handshake(2'b11);
        repeat (2) @(negedge clk);
        check("f3_in_fetch", CW'({busy, dbg_state}), CW'(4'b1001));
        rst_n = 1'b0;
        #1;
        check("abort_outs", CW'({fetch_req, fetch_addr, res_valid, res_data, res_mode,
                                 res_sad, busy, frame_done, dbg_state}), CW'(0));
        exp_addr_q.delete();
        repeat (2) @(negedge clk);
        check("abort_no_frame_done", CW'(fd_count), CW'(2));
        rst_n = 1'b1;

        // Frame 4: restart from (0,0), forced-mode fallbacks and two-sided DC.
        push_addrs();
        push_exp(2'b00, 1648, rows_res(-118, -108, -98, -88));
        push_exp(2'b00, 160, rows_res(-15, -5, 5, 15));
        push_exp(2'b00, 160, rows_res(10, 10, 10, 10));
        push_exp(2'b00, 80, rows_res(-5, -5, -5, -5));
        start_frame(2'b01);
        check_block("f4b0"); do_handshake(2'b10);
        check_block("f4b1"); do_handshake(2'b11);
        check_block("f4b2"); do_handshake(2'b00);
        check_block("f4b3"); do_handshake(2'b11);
        repeat (3) @(negedge clk);
        check("f4_frame_done", CW'(fd_count), CW'(3));
        check("f4_idle", CW'({busy, dbg_state}), CW'(0));
        check("f4_addr_left", CW'(exp_addr_q.size()), CW'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
